// File: rtl/onehot_step_decoder.sv
// onehot_step_decoder: registered N-to-2^N one-hot decoder over an internal
// index. The index can be loaded from a binary select, or stepped up or down
// with wrap at LIMIT. All outputs come straight from flops, so the one-hot
// strobe never glitches and no input reaches an output combinationally.
//
// There is no handshake: every input is sampled on each rising edge, and
// every output reflects that sample one edge later.
module onehot_step_decoder #(
    parameter int N     = 2,
    parameter int LIMIT = (1 << N) - 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                load,
    input  logic                step,
    input  logic                dir,
    input  logic [N-1:0]        select,
    output logic [(1<<N)-1:0]   decoded_op,
    output logic [N-1:0]        index,
    output logic                wrap,
    output logic                err
);

    localparam int              W       = 1 << N;
    localparam logic [N-1:0]    LIMIT_V = N'(LIMIT);
    localparam logic [N-1:0]    ONE     = N'(1);
    localparam logic [W-1:0]    ONE_HOT = W'(1);

    logic [N-1:0] index_q, index_d;
    logic [W-1:0] decoded_q, decoded_d;
    logic         wrap_q, wrap_d;
    logic         err_q, err_d;

    // Next index: load beats step, step beats hold. Wrap is decided against
    // LIMIT, not by natural overflow, so a short index range wraps correctly.
    always_comb begin
        index_d = index_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            if (select > LIMIT_V) begin
                err_d = 1'b1;
            end else begin
                index_d = select;
            end
        end else if (step) begin
            if (!dir) begin
                if (index_q == LIMIT_V) begin
                    index_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    index_d = index_q + ONE;
                end
            end else begin
                if (index_q == '0) begin
                    index_d = LIMIT_V;
                    wrap_d  = 1'b1;
                end else begin
                    index_d = index_q - ONE;
                end
            end
        end
        // Decode from the index being written this edge, so index and
        // decoded_op always agree.
        decoded_d = en ? (ONE_HOT << index_d) : '0;
    end

    // State and output registers; async reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q   <= '0;
            decoded_q <= '0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            index_q   <= index_d;
            decoded_q <= decoded_d;
            wrap_q    <= wrap_d;
            err_q     <= err_d;
        end
    end

    assign decoded_op = decoded_q;
    assign index      = index_q;
    assign wrap       = wrap_q;
    assign err        = err_q;

endmodule

// File: tb/tb_onehot_step_decoder.sv
// Bench for onehot_step_decoder (N=3, LIMIT=5). The driver pushes each
// expected response from a modular-arithmetic reference model; the monitor
// pops it and compares one edge later.
module tb_onehot_step_decoder;

  localparam int N     = 3;
  localparam int LIMIT = 5;
  localparam int W     = 1 << N;
  localparam int EW    = W + N + 2;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         load;
  logic         step;
  logic         dir;
  logic [N-1:0] select;
  logic [W-1:0] decoded_op;
  logic [N-1:0] index;
  logic         wrap;
  logic         err;

  onehot_step_decoder #(.N(N), .LIMIT(LIMIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .step       (step),
    .dir        (dir),
    .select     (select),
    .decoded_op (decoded_op),
    .index      (index),
    .wrap       (wrap),
    .err        (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected packing: {decoded_op, index, wrap, err}
  logic [EW-1:0] exp_q[$];

  // Reference model state
  int model_idx = 0;

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model_step(input bit m_en, input bit m_load,
                                               input bit m_step, input bit m_dir,
                                               input int m_sel);
    int nxt;
    bit w;
    bit e;
    logic [W-1:0] dec;
    nxt = model_idx;
    w   = 1'b0;
    e   = 1'b0;
    if (m_load) begin
      if (m_sel > LIMIT) e = 1'b1;
      else nxt = m_sel;
    end else if (m_step) begin
      if (!m_dir) begin
        w   = (model_idx == LIMIT);
        nxt = (model_idx + 1) % (LIMIT + 1);
      end else begin
        w   = (model_idx == 0);
        nxt = (model_idx + LIMIT) % (LIMIT + 1);
      end
    end
    model_idx = nxt;
    dec = '0;
    if (m_en) dec[nxt] = 1'b1;
    return {dec, N'(nxt), w, e};
  endfunction

  // ---------------- driver tasks ----------------
  // Apply inputs (called just after a falling edge) and queue the response.
  task automatic drive(input bit d_en, input bit d_load, input bit d_step,
                       input bit d_dir, input int d_sel);
    en     = d_en;
    load   = d_load;
    step   = d_step;
    dir    = d_dir;
    select = N'(d_sel);
    exp_q.push_back(model_step(d_en, d_load, d_step, d_dir, d_sel));
  endtask

  task automatic cycle(input bit d_en, input bit d_load, input bit d_step,
                       input bit d_dir, input int d_sel);
    @(negedge clk);
    drive(d_en, d_load, d_step, d_dir, d_sel);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (decoded_op !== '0 || index !== '0 || wrap !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL %s got dec=%b idx=%0d wrap=%b err=%b exp all zero",
               name, decoded_op, index, wrap, err);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [EW-1:0] exp_v;
    logic [EW-1:0] act_v;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {decoded_op, index, wrap, err};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL response got dec=%b idx=%0d wrap=%b err=%b exp dec=%b idx=%0d wrap=%b err=%b",
                 act_v[EW-1 -: W], act_v[N+1:2], act_v[1], act_v[0],
                 exp_v[EW-1 -: W], exp_v[N+1:2], exp_v[1], exp_v[0]);
      end
      // One-hot/index invariant, independent of the model.
      checks++;
      if (decoded_op !== '0 && decoded_op !== (W'(1) << index)) begin
        failures++;
        $display("FAIL onehot_invariant got dec=%b idx=%0d exp zero or 1<<idx",
                 decoded_op, index);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    load   = 1'b0;
    step   = 1'b0;
    dir    = 1'b0;
    select = '0;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset_hold");

    // Release and first cycles: enable then disable.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 0);        // dec=00000001 idx=0
    cycle(0, 0, 0, 0, 0);        // dec=0
    cycle(1, 0, 0, 0, 0);

    // Up-step 7 edges: 1,2,3,4,5,0,1 with wrap on return to 0.
    for (int i = 0; i < 7; i++) cycle(1, 0, 1, 0, 0);

    // Down-step: load 1, then 0,5,4.
    cycle(1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 1, 0);

    // Load, rejected load, load beating step.
    cycle(1, 1, 0, 0, 4);
    cycle(1, 1, 0, 0, 6);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 2);
    cycle(1, 1, 1, 1, 7);        // rejected; step ignored

    // Sweep all selects with en=1, then en=0.
    for (int s = 0; s < W; s++) cycle(1, 1, 0, 0, s);
    for (int s = 0; s < W; s++) cycle(0, 1, 0, 0, s);

    // Stepping while disabled still moves the index.
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);

    // Async reset mid-run while stepping at index 2.
    cycle(1, 1, 0, 0, 1);
    cycle(1, 0, 1, 0, 0);        // index 2
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_idx = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 1, 0, 0);        // resumes from 0 -> 1
    cycle(1, 0, 1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, W - 1));
    end

    // Drain with a bounded wait.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending=%0d exp 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
